// File: rtl/float_addsub_unit_pkg.sv
// rtl/float_addsub_unit_pkg.sv - float field helpers, format constants and FSM states for float_addsub_unit
package float_addsub_unit_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 7;
  localparam int GUARD_W = 3;
  localparam int SIG_W   = 1 + MAN_W + GUARD_W;

  localparam int FBIAS    = 127;
  localparam int FEXP_MAX = 255;

  localparam logic [15:0] FINF  = 16'h7F80;
  localparam logic [15:0] FQNAN = 16'h7FC0;
  localparam logic [15:0] FZERO = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_PACK  = 3'd4
  } state_t;

  function automatic logic f_sign(input logic [15:0] f);
    return f[15];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [15:0] f);
    return f[14:7];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [15:0] f);
    return f[6:0];
  endfunction

endpackage

// File: rtl/float_lzc12.sv
// rtl/float_lzc12.sv - combinational 12-bit leading-zero counter (0..12), nibble tree
module float_lzc12 (
  input  logic [11:0] data_i,
  output logic [3:0]  count_o
);

  function automatic logic [2:0] lzc4(input logic [3:0] n);
    casez (n)
      4'b1???: return 3'd0;
      4'b01??: return 3'd1;
      4'b001?: return 3'd2;
      4'b0001: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  logic [2:0] lz_hi, lz_mid, lz_lo;

  always_comb begin
    lz_hi  = lzc4(data_i[11:8]);
    lz_mid = lzc4(data_i[7:4]);
    lz_lo  = lzc4(data_i[3:0]);
    if (lz_hi != 3'd4)       count_o = {1'b0, lz_hi};
    else if (lz_mid != 3'd4) count_o = 4'd4 + {1'b0, lz_mid};
    else                     count_o = 4'd8 + {1'b0, lz_lo};
  end

endmodule

// File: rtl/float_addsub_unit.sv
// rtl/float_addsub_unit.sv - multi-cycle 16-bit float add/sub, 4-cycle latency
// FADDSUB_ROUND_EN: sticky collection in ALIGN and round-to-nearest-even in PACK (default truncates)
module float_addsub_unit
  import float_addsub_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero
);

  state_t             state_q;
  logic [15:0]        a_q, b_q, spec_res_q, result_q;
  logic               sub_q, sx_q, sy_q, spec_q, sign_q, nzero_q;
  logic               busy_q, done_q, zero_q;
  logic signed [9:0]  ex_q, nexp_q;
  logic [SIG_W-1:0]   sigx_q, sigy_q, nsig_q;
  logic [SIG_W:0]     sum_q;

  logic [EXP_W-1:0]   ea, eb, ex_d, ey_d, shamt;
  logic [MAN_W-1:0]   ma, mb, mx_d, my_d;
  logic               sa, sb, swap, sx_d, sy_d, inf_a, inf_b, spec_d;
  logic [15:0]        spec_res_d, pack_res_d;
  logic [SIG_W-1:0]   sigx_d, sigy_full, sigy_d, nsig_d;
  logic               eff_sub, sign_d;
  logic [SIG_W:0]     sum_d;
  logic [3:0]         lz, nshift;
  logic signed [9:0]  nexp_d, pexp;
  logic [MAN_W:0]     man_r;
  logic               unused_bits;

  // ALIGN: order operands by magnitude, then shift the smaller one down
  always_comb begin
    ea    = f_exp(a_q);
    eb    = f_exp(b_q);
    ma    = (ea == '0) ? '0 : f_man(a_q);
    mb    = (eb == '0) ? '0 : f_man(b_q);
    sa    = f_sign(a_q);
    sb    = f_sign(b_q) ^ sub_q;
    swap  = {eb, mb} > {ea, ma};
    ex_d  = swap ? eb : ea;
    ey_d  = swap ? ea : eb;
    mx_d  = swap ? mb : ma;
    my_d  = swap ? ma : mb;
    sx_d  = swap ? sb : sa;
    sy_d  = swap ? sa : sb;
    sigx_d    = {ex_d != '0, mx_d, {GUARD_W{1'b0}}};
    sigy_full = {ey_d != '0, my_d, {GUARD_W{1'b0}}};
    shamt     = ex_d - ey_d;
    sigy_d    = (shamt >= EXP_W'(SIG_W)) ? '0 : sigy_full >> shamt;
`ifdef FADDSUB_ROUND_EN
    if (shamt >= EXP_W'(SIG_W)) sigy_d[0] = |sigy_full;
    else sigy_d[0] = sigy_d[0] | (|(sigy_full & ~({SIG_W{1'b1}} << shamt)));
`endif
    inf_a  = (ea == EXP_W'(FEXP_MAX));
    inf_b  = (eb == EXP_W'(FEXP_MAX));
    spec_d = inf_a | inf_b;
    if (inf_a && inf_b) spec_res_d = (sa != sb) ? FQNAN : {sa, FINF[14:0]};
    else if (inf_a)     spec_res_d = {sa, FINF[14:0]};
    else                spec_res_d = {sb, FINF[14:0]};
  end

  always_comb begin
    eff_sub = sx_q ^ sy_q;
    sum_d   = eff_sub ? ({1'b0, sigx_q} - {1'b0, sigy_q})
                      : ({1'b0, sigx_q} + {1'b0, sigy_q});
    sign_d  = (eff_sub && sum_d == '0) ? 1'b0 : sx_q;
  end

  float_lzc12 u_lzc (
    .data_i  (sum_q),
    .count_o (lz)
  );

  always_comb begin
    nshift = lz - 4'd1;
    if (sum_q[SIG_W]) begin
      nsig_d = sum_q[SIG_W:1];
`ifdef FADDSUB_ROUND_EN
      nsig_d[0] = sum_q[1] | sum_q[0];
`endif
      nexp_d = ex_q + 10'sd1;
    end else begin
      nsig_d = sum_q[SIG_W-1:0] << nshift;
      nexp_d = ex_q - $signed({6'd0, nshift});
    end
  end

  always_comb begin
    man_r = {1'b0, nsig_q[SIG_W-2:GUARD_W]};
    pexp  = nexp_q;
`ifdef FADDSUB_ROUND_EN
    if (nsig_q[GUARD_W-1] && ((|nsig_q[GUARD_W-2:0]) || nsig_q[GUARD_W])) begin
      man_r = man_r + 1'b1;
      if (man_r[MAN_W]) pexp = nexp_q + 10'sd1;
    end
`endif
    if (spec_q)                          pack_res_d = spec_res_q;
    else if (nzero_q || int'(pexp) <= 0) pack_res_d = FZERO;
    else if (int'(pexp) >= FEXP_MAX)     pack_res_d = {sign_q, FINF[14:0]};
    else pack_res_d = {sign_q, pexp[EXP_W-1:0], man_r[MAN_W-1:0]};
  end

  assign unused_bits = ^{nsig_q[SIG_W-1], nsig_q[GUARD_W-1:0], pexp[9:8], man_r[MAN_W]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;   a_q <= '0;    b_q <= '0;     sub_q <= 1'b0;
      sx_q <= 1'b0;        sy_q <= 1'b0; ex_q <= '0;    sigx_q <= '0;
      sigy_q <= '0;        spec_q <= 1'b0; spec_res_q <= '0;
      sum_q <= '0;         sign_q <= 1'b0; nsig_q <= '0; nexp_q <= '0;
      nzero_q <= 1'b0;     busy_q <= 1'b0; done_q <= 1'b0;
      result_q <= FZERO;   zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          a_q <= a; b_q <= b; sub_q <= sub;
          busy_q  <= 1'b1;
          state_q <= S_ALIGN;
        end
        S_ALIGN: begin
          sx_q <= sx_d; sy_q <= sy_d; ex_q <= $signed({2'b00, ex_d});
          sigx_q <= sigx_d; sigy_q <= sigy_d;
          spec_q <= spec_d; spec_res_q <= spec_res_d;
          state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q <= sum_d; sign_q <= sign_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          nsig_q <= nsig_d; nexp_q <= nexp_d; nzero_q <= (sum_q == '0);
          state_q <= S_PACK;
        end
        S_PACK: begin
          result_q <= pack_res_d;
          zero_q   <= (pack_res_d == FZERO);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule
